instruction_fetch_sequencer: RTL and testbench



---
 rtl/instruction_fetch_sequencer.sv | 172 +++++++++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_fetch_sequencer
//
// Sequences the SAP-2 fetch cycle. It walks the PC/MAR/memory/IR controls
// through the op-code fetch, decodes the instruction length from the
// op code, fetches up to two operand bytes from the WBUS and then hands the
// instruction to the execute controller.
//
// Handshake with the execute controller: exec_start pulses for exactly one
// cycle, the first cycle of each EXEC visit. The sequencer stays in EXEC
// until exec_done is sampled high on a rising edge (that may be the same
// cycle as exec_start). exec_done is ignored in every other state.
//
// Ports
//   CLK         clock, rising edge
//   nCLR        asynchronous active-low clear
//   opcode      op code from the IR, valid from the falling edge in F_MEM
//   WBUS        bus data, captured as an operand when leaving O_MEM
//   exec_done   execute controller finished the current instruction
//   Ep          PC drives WBUS (active high)
//   nLm         MAR loads from WBUS (active low)
//   Cp          PC increment (active high)
//   nCE         memory drives WBUS (active low)
//   nLi         IR loads from WBUS (active low)
//   exec_start  one-cycle pulse: instruction and operands ready
//   operand_lo  first operand byte (low byte / immediate)
//   operand_hi  second operand byte (high address byte)
//   instr_len   length of current instruction (1..3), 0 before first decode
//   halted      sequencer stopped on HLT
//   state       current state encoding, for debug
// ---------------------------------------------------------------------------
module instruction_fetch_sequencer #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] HLT_OPCODE = 8'h76
) (
    input  logic                  CLK,
    input  logic                  nCLR,
    input  logic [DATA_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0] WBUS,
    input  logic                  exec_done,
    output logic                  Ep,
    output logic                  nLm,
    output logic                  Cp,
    output logic                  nCE,
    output logic                  nLi,
    output logic                  exec_start,
    output logic [DATA_WIDTH-1:0] operand_lo,
    output logic [DATA_WIDTH-1:0] operand_hi,
    output logic [1:0]            instr_len,
    output logic                  halted,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F_ADDR = 4'd1,
        S_F_INCR = 4'd2,
        S_F_MEM  = 4'd3,
        S_O_ADDR = 4'd4,
        S_O_INCR = 4'd5,
        S_O_MEM  = 4'd6,
        S_EXEC   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            w_len;
    logic [1:0]            r_remaining;
    logic                  r_ep, r_nlm, r_cp, r_nce, r_nli;
    logic                  r_exec_start, r_halted;
    logic [DATA_WIDTH-1:0] r_operand_lo, r_operand_hi;
    logic [1:0]            r_instr_len;

    // Instruction length from the op code.
    always_comb begin
        w_len = 2'd1;
        case (opcode)
            8'hC2, 8'hC3, 8'hCA, 8'hCD, 8'hFA, 8'h3A, 8'h32:
                w_len = 2'd3;
            8'h06, 8'h0E, 8'h3E, 8'hDB, 8'hD3, 8'hE6, 8'hEE, 8'hF6:
                w_len = 2'd2;
            default:
                w_len = 2'd1;
        endcase
    end

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = S_F_ADDR;
            S_F_ADDR: w_next = S_F_INCR;
            S_F_INCR: w_next = S_F_MEM;
            S_F_MEM: begin
                if (opcode == HLT_OPCODE)
                    w_next = S_HALT;
                else if (w_len > 2'd1)
                    w_next = S_O_ADDR;
                else
                    w_next = S_EXEC;
            end
            S_O_ADDR: w_next = S_O_INCR;
            S_O_INCR: w_next = S_O_MEM;
            S_O_MEM:  w_next = (r_remaining > 2'd1) ? S_O_ADDR : S_EXEC;
            S_EXEC:   w_next = exec_done ? S_F_ADDR : S_EXEC;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // State, datapath registers and control outputs. Controls are registered
    // from the next state so each one is a pure function of the state held.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            r_state      <= S_IDLE;
            r_remaining  <= 2'd0;
            r_operand_lo <= '0;
            r_operand_hi <= '0;
            r_instr_len  <= 2'd0;
            r_ep         <= 1'b0;
            r_nlm        <= 1'b1;
            r_cp         <= 1'b0;
            r_nce        <= 1'b1;
            r_nli        <= 1'b1;
            r_exec_start <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_F_MEM && opcode != HLT_OPCODE) begin
                r_instr_len  <= w_len;
                r_remaining  <= w_len - 2'd1;
                r_operand_lo <= '0;
                r_operand_hi <= '0;
            end

            if (r_state == S_O_MEM) begin
                // First operand of the instruction goes to the low byte:
                // that is the only operand of a 2-byte instruction, or the
                // one fetched while two remain for a 3-byte instruction.
                if (r_instr_len == 2'd2 || r_remaining == 2'd2)
                    r_operand_lo <= WBUS;
                else
                    r_operand_hi <= WBUS;
                r_remaining <= r_remaining - 2'd1;
            end

            r_ep         <= (w_next == S_F_ADDR) || (w_next == S_O_ADDR);
            r_nlm        <= !((w_next == S_F_ADDR) || (w_next == S_O_ADDR));
            r_cp         <= (w_next == S_F_INCR) || (w_next == S_O_INCR);
            r_nce        <= !((w_next == S_F_MEM) || (w_next == S_O_MEM));
            r_nli        <= !(w_next == S_F_MEM);
            r_halted     <= (w_next == S_HALT);
            // Pulse only on entry into EXEC, not while waiting there.
            r_exec_start <= (w_next == S_EXEC) && (r_state != S_EXEC);
        end
    end

    assign Ep         = r_ep;
    assign nLm        = r_nlm;
    assign Cp         = r_cp;
    assign nCE        = r_nce;
    assign nLi        = r_nli;
    assign exec_start = r_exec_start;
    assign operand_lo = r_operand_lo;
    assign operand_hi = r_operand_hi;
    assign instr_len  = r_instr_len;
    assign halted     = r_halted;
    assign state      = r_state;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
module tb_instruction_fetch_sequencer;

  logic       CLK;
  logic       nCLR;
  logic [7:0] opcode;
  logic [7:0] WBUS;
  logic       exec_done;
  logic       Ep, nLm, Cp, nCE, nLi;
  logic       exec_start;
  logic [7:0] operand_lo, operand_hi;
  logic [1:0] instr_len;
  logic       halted;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle observations captured by the driver.
  logic [3:0] tr_state[$];
  logic [4:0] tr_ctrl[$];
  logic       tr_start[$];
  logic       tr_halt[$];
  logic [7:0] tr_lo[$];
  logic [7:0] tr_hi[$];
  logic [1:0] tr_len[$];

  instruction_fetch_sequencer #(
    .DATA_WIDTH(8),
    .HLT_OPCODE(8'h76)
  ) dut (
    .CLK       (CLK),
    .nCLR      (nCLR),
    .opcode    (opcode),
    .WBUS      (WBUS),
    .exec_done (exec_done),
    .Ep        (Ep),
    .nLm       (nLm),
    .Cp        (Cp),
    .nCE       (nCE),
    .nLi       (nLi),
    .exec_start(exec_start),
    .operand_lo(operand_lo),
    .operand_hi(operand_hi),
    .instr_len (instr_len),
    .halted    (halted),
    .state     (state)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- reference model ----------------
  function automatic int spec_len(input logic [7:0] op);
    if (op inside {8'hC2, 8'hC3, 8'hCA, 8'hCD, 8'hFA, 8'h3A, 8'h32}) return 3;
    if (op inside {8'h06, 8'h0E, 8'h3E, 8'hDB, 8'hD3, 8'hE6, 8'hEE, 8'hF6}) return 2;
    return 1;
  endfunction

  // {Ep, nLm, Cp, nCE, nLi} expected in a given state.
  function automatic logic [4:0] spec_ctrl(input int st);
    case (st)
      1, 4:    return 5'b10011;
      2, 5:    return 5'b01111;
      3:       return 5'b01000;
      6:       return 5'b01001;
      default: return 5'b01011;
    endcase
  endfunction

  // State during cycle k of an instruction of n bytes (cycle 0 = F_ADDR).
  function automatic int exp_state(input int k, input int n);
    if (k < 3) return 1 + k;
    if (k < 3 * n) return 4 + (k - 3) % 3;
    return 7;
  endfunction

  // ---------------- driver ----------------
  // Runs ncyc cycles of one instruction, starting with the DUT about to be
  // in F_ADDR. Inputs are meaningful only where the fetch schedule uses
  // them; elsewhere they carry random junk.
  task automatic run_instr(input logic [7:0] opc, input logic [7:0] b0,
                           input logic [7:0] b1, input int hold, input int ncyc);
    int n;
    n = spec_len(opc);
    tr_state.delete(); tr_ctrl.delete(); tr_start.delete(); tr_halt.delete();
    tr_lo.delete(); tr_hi.delete(); tr_len.delete();
    for (int k = 0; k < ncyc; k++) begin
      @(negedge CLK);
      tr_state.push_back(state);
      tr_ctrl.push_back({Ep, nLm, Cp, nCE, nLi});
      tr_start.push_back(exec_start);
      tr_halt.push_back(halted);
      tr_lo.push_back(operand_lo);
      tr_hi.push_back(operand_hi);
      tr_len.push_back(instr_len);
      opcode = (k == 2) ? opc : 8'($urandom_range(0, 255));
      if (k >= 3 && k < 3 * n && (k - 3) % 3 == 2)
        WBUS = (k < 6) ? b0 : b1;
      else
        WBUS = 8'($urandom_range(0, 255));
      if (k >= 3 * n)
        exec_done = (k == 3 * n + hold);
      else
        exec_done = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nCLR = 1'b0; opcode = 8'h00; WBUS = 8'h00; exec_done = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (state !== 4'd0 || {Ep, nLm, Cp, nCE, nLi} !== 5'b01011 || exec_start !== 1'b0 ||
        halted !== 1'b0 || operand_lo !== 8'h00 || operand_hi !== 8'h00 || instr_len !== 2'd0) begin
      n_errors++;
      $display("FAIL reset: state=%0d ctrl=%b start=%b halted=%b lo=%h hi=%h len=%0d, expected 0 01011 0 0 00 00 0",
               state, {Ep, nLm, Cp, nCE, nLi}, exec_start, halted, operand_lo, operand_hi, instr_len);
    end
    nCLR = 1'b1;
  endtask

  task automatic test_fetch_lengths();
    logic [7:0] t_op[5] = '{8'h80, 8'h3E, 8'hC3, 8'h00, 8'hCD};
    logic [7:0] t_b0[5] = '{8'h00, 8'h5A, 8'h34, 8'h00, 8'hA5};
    logic [7:0] t_b1[5] = '{8'h00, 8'h00, 8'h12, 8'h00, 8'h3C};
    int         t_hold[5] = '{0, 0, 0, 4, 2};
    for (int t = 0; t < 5; t++) begin
      int n;
      n = spec_len(t_op[t]);
      run_instr(t_op[t], t_b0[t], t_b1[t], t_hold[t], 3 * n + t_hold[t] + 1);
      for (int k = 0; k < 3 * n + t_hold[t] + 1; k++) begin
        int es;
        es = exp_state(k, n);
        n_checks++;
        if (tr_state[k] !== 4'(es) || tr_ctrl[k] !== spec_ctrl(es) ||
            tr_start[k] !== (k == 3 * n) || tr_halt[k] !== 1'b0) begin
          n_errors++;
          $display("FAIL fetch op=%h cycle %0d: state=%0d ctrl=%b start=%b halted=%b, expected state=%0d ctrl=%b start=%b halted=0",
                   t_op[t], k, tr_state[k], tr_ctrl[k], tr_start[k], tr_halt[k], es, spec_ctrl(es), (k == 3 * n));
        end
        if (k >= 3 * n) begin
          n_checks++;
          if (tr_len[k] !== 2'(n) || tr_lo[k] !== ((n >= 2) ? t_b0[t] : 8'h00) ||
              tr_hi[k] !== ((n == 3) ? t_b1[t] : 8'h00)) begin
            n_errors++;
            $display("FAIL operands op=%h cycle %0d: len=%0d lo=%h hi=%h, expected len=%0d lo=%h hi=%h",
                     t_op[t], k, tr_len[k], tr_lo[k], tr_hi[k], n,
                     (n >= 2) ? t_b0[t] : 8'h00, (n == 3) ? t_b1[t] : 8'h00);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] len3[7] = '{8'hC2, 8'hC3, 8'hCA, 8'hCD, 8'hFA, 8'h3A, 8'h32};
    logic [7:0] len2[8] = '{8'h06, 8'h0E, 8'h3E, 8'hDB, 8'hD3, 8'hE6, 8'hEE, 8'hF6};
    for (int t = 0; t < 40; t++) begin
      logic [7:0] op, b0, b1;
      int         hold, n, kind;
      kind = $urandom_range(0, 2);
      if (kind == 0)      op = len3[$urandom_range(0, 6)];
      else if (kind == 1) op = len2[$urandom_range(0, 7)];
      else                op = 8'($urandom_range(0, 255));
      if (op == 8'h76) op = 8'h00;
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      hold = $urandom_range(0, 3);
      n = spec_len(op);
      run_instr(op, b0, b1, hold, 3 * n + hold + 1);
      for (int k = 0; k < 3 * n + hold + 1; k++) begin
        int es;
        es = exp_state(k, n);
        n_checks++;
        if (tr_state[k] !== 4'(es) || tr_ctrl[k] !== spec_ctrl(es) ||
            tr_start[k] !== (k == 3 * n) || tr_halt[k] !== 1'b0) begin
          n_errors++;
          $display("FAIL random op=%h cycle %0d: state=%0d ctrl=%b start=%b, expected state=%0d ctrl=%b start=%b",
                   op, k, tr_state[k], tr_ctrl[k], tr_start[k], es, spec_ctrl(es), (k == 3 * n));
        end
        if (k >= 3 * n) begin
          n_checks++;
          if (tr_len[k] !== 2'(n) || tr_lo[k] !== ((n >= 2) ? b0 : 8'h00) ||
              tr_hi[k] !== ((n == 3) ? b1 : 8'h00)) begin
            n_errors++;
            $display("FAIL random operands op=%h cycle %0d: len=%0d lo=%h hi=%h, expected len=%0d lo=%h hi=%h",
                     op, k, tr_len[k], tr_lo[k], tr_hi[k], n,
                     (n >= 2) ? b0 : 8'h00, (n == 3) ? b1 : 8'h00);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [7:0] b0, b1;
    b0 = 8'($urandom_range(1, 255));
    b1 = 8'($urandom_range(1, 255));
    // Cycles 0..7: stop inside the second operand's O_INCR.
    run_instr(8'hCD, b0, b1, 0, 8);
    n_checks++;
    if (tr_state[7] !== 4'd5 || Cp !== 1'b1 || operand_lo !== b0 || instr_len !== 2'd3) begin
      n_errors++;
      $display("FAIL mid_fetch_pre: state=%0d Cp=%b lo=%h len=%0d, expected 5 1 %h 3",
               tr_state[7], Cp, operand_lo, instr_len, b0);
    end
    #1 nCLR = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || Cp !== 1'b0 || operand_lo !== 8'h00 || operand_hi !== 8'h00 ||
        instr_len !== 2'd0 || {Ep, nLm, Cp, nCE, nLi} !== 5'b01011) begin
      n_errors++;
      $display("FAIL mid_fetch_reset: state=%0d ctrl=%b lo=%h hi=%h len=%0d, expected 0 01011 00 00 0",
               state, {Ep, nLm, Cp, nCE, nLi}, operand_lo, operand_hi, instr_len);
    end
    @(negedge CLK);
    n_checks++;
    if (state !== 4'd0) begin
      n_errors++;
      $display("FAIL mid_fetch_hold: state=%0d, expected 0", state);
    end
    nCLR = 1'b1;
  endtask

  task automatic test_halt();
    run_instr(8'h76, 8'h00, 8'h00, 0, 3);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (tr_state[k] !== 4'(k + 1) || tr_ctrl[k] !== spec_ctrl(k + 1)) begin
        n_errors++;
        $display("FAIL halt_fetch cycle %0d: state=%0d ctrl=%b, expected %0d %b",
                 k, tr_state[k], tr_ctrl[k], k + 1, spec_ctrl(k + 1));
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      n_checks++;
      if (state !== 4'd8 || halted !== 1'b1 || {Ep, nLm, Cp, nCE, nLi} !== 5'b01011 || exec_start !== 1'b0) begin
        n_errors++;
        $display("FAIL halt cycle %0d: state=%0d halted=%b ctrl=%b start=%b, expected 8 1 01011 0",
                 c, state, halted, {Ep, nLm, Cp, nCE, nLi}, exec_start);
      end
      exec_done = 1'($urandom_range(0, 1));
      opcode = 8'($urandom_range(0, 255));
    end
    #1 nCLR = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || halted !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_clear: state=%0d halted=%b, expected 0 0", state, halted);
    end
    @(negedge CLK);
    nCLR = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (state !== 4'd1 || {Ep, nLm, Cp, nCE, nLi} !== 5'b10011) begin
      n_errors++;
      $display("FAIL halt_restart: state=%0d ctrl=%b, expected 1 10011", state, {Ep, nLm, Cp, nCE, nLi});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fetch_lengths();
    test_random();
    test_reset_mid_fetch();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
